// File: rtl/cd_digit_scan_mux.sv
// Four-digit scan driver: one nibble and one active-low anode at a time, with a blank gap between digits.
// A pending word is held in a shadow register and lands on disp only at the digit 3 -> digit 0 wrap.
module cd_digit_scan_mux #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  blank_mask,
  output logic        D,
  output logic        C,
  output logic        B,
  output logic        A,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int MAXC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {SHOW, BLANK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SHOW;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      disp_q   <= 16'h0000;
      pend_q   <= 16'h0000;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = SHOW;
          idx_d   = idx_q + 2'd1;
          // Frame boundary: only place the shown word may change.
          if (idx_q == 2'd3 && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
          end
        end
      end
      default: state_d = SHOW;
    endcase
    // A load on the commit edge refills the shadow for the next frame.
    if (load) begin
      pend_d   = din;
      pend_v_d = 1'b1;
    end
  end

  assign {D, C, B, A} = disp_q[{idx_q, 2'b00} +: 4];
  assign an           = (state_q == BLANK) ? 4'b1111 : (~(4'b0001 << idx_q) | blank_mask);
  assign pending      = pend_v_q;

endmodule

// File: tb/tb_cd_digit_scan_mux.sv
// Directed bench for cd_digit_scan_mux with CLK_DIV=4, BLANK_CYC=2 (24-cycle frame).
module tb_cd_digit_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  blank_mask;
  wire         D, C, B, A;
  wire  [3:0]  an;
  wire         pending;
  wire  [3:0]  dcba = {D, C, B, A};

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  bit mon_en   = 1'b0;

  cd_digit_scan_mux #(.CLK_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .load(load), .din(din), .blank_mask(blank_mask),
    .D(D), .C(C), .B(B), .A(A), .an(an), .pending(pending)
  );

  always #5 clk = ~clk;

  // Hand-written anode table for one frame; masked variant for blank_mask=0101.
  function automatic logic [3:0] an_tab(input int p, input bit masked);
    logic [3:0] v;
    if      (p <= 3)  v = masked ? 4'b1111 : 4'b1110;
    else if (p <= 5)  v = 4'b1111;
    else if (p <= 9)  v = 4'b1101;
    else if (p <= 11) v = 4'b1111;
    else if (p <= 15) v = masked ? 4'b1111 : 4'b1011;
    else if (p <= 17) v = 4'b1111;
    else if (p <= 21) v = 4'b0111;
    else              v = 4'b1111;
    return v;
  endfunction

  function automatic logic [3:0] nib(input logic [15:0] w, input int p);
    logic [15:0] s;
    s = w >> (4 * (p / 6));
    return s[3:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 24;
  endtask

  task automatic goto_pos(input int target);
    for (int k = 0; k < 24 && pos != target; k++) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL overlap: an=%b has more than one low bit", an);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; din = 16'hFFFF; blank_mask = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (an !== 4'b1110 || dcba !== 4'b0000 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: an=%b dcba=%b pending=%b, want 1110 0000 0", an, dcba, pending);
    end
    rst = 1'b0; load = 1'b0; pos = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 48; k++) begin
      n_checks++;
      if (an !== an_tab(pos, 1'b0) || dcba !== 4'b0000 || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL idle pos%0d: an=%b dcba=%b pending=%b, want %b 0000 0",
                 pos, an, dcba, pending, an_tab(pos, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_load_visible();
    goto_pos(6);
    load = 1'b1; din = 16'h4321;
    tick();
    load = 1'b0;
    for (int k = 0; k < 24 && pos != 0; k++) begin
      n_checks++;
      if (pending !== 1'b1 || dcba !== 4'b0000) begin
        n_fail++;
        $display("FAIL load_wait pos%0d: pending=%b dcba=%b, want 1 0000", pos, pending, dcba);
      end
      tick();
    end
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (an !== an_tab(pos, 1'b0) || dcba !== nib(16'h4321, pos) || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL load_show pos%0d: an=%b dcba=%b pending=%b, want %b %b 0",
                 pos, an, dcba, pending, an_tab(pos, 1'b0), nib(16'h4321, pos));
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    goto_pos(2);
    load = 1'b1; din = 16'hAAAA;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; din = 16'h5555;
    tick();
    load = 1'b0;
    for (int k = 0; k < 24 && pos != 0; k++) begin
      n_checks++;
      if (pending !== 1'b1 || dcba !== nib(16'h4321, pos)) begin
        n_fail++;
        $display("FAIL b2b_wait pos%0d: pending=%b dcba=%b, want 1 %b", pos, pending, dcba, nib(16'h4321, pos));
      end
      tick();
    end
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (dcba !== 4'b0101 || an !== an_tab(pos, 1'b0) || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_show pos%0d: dcba=%b an=%b pending=%b, want 0101 %b 0",
                 pos, dcba, an, pending, an_tab(pos, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_commit_collision();
    goto_pos(8);
    load = 1'b1; din = 16'h1111;
    tick();
    load = 1'b0;
    goto_pos(23);
    load = 1'b1; din = 16'h9876;
    tick();
    load = 1'b0;
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (dcba !== 4'b0001 || pending !== 1'b1 || an !== an_tab(pos, 1'b0)) begin
        n_fail++;
        $display("FAIL collide_f1 pos%0d: dcba=%b pending=%b an=%b, want 0001 1 %b",
                 pos, dcba, pending, an, an_tab(pos, 1'b0));
      end
      tick();
    end
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (dcba !== nib(16'h9876, pos) || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL collide_f2 pos%0d: dcba=%b pending=%b, want %b 0",
                 pos, dcba, pending, nib(16'h9876, pos));
      end
      tick();
    end
  endtask

  task automatic test_blank_mask();
    blank_mask = 4'b0101;
    #1;
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (an !== an_tab(pos, 1'b1) || dcba !== nib(16'h9876, pos)) begin
        n_fail++;
        $display("FAIL mask pos%0d: an=%b dcba=%b, want %b %b",
                 pos, an, dcba, an_tab(pos, 1'b1), nib(16'h9876, pos));
      end
      tick();
    end
    blank_mask = 4'b0000;
    #1;
    n_checks++;
    if (an !== 4'b1110) begin
      n_fail++;
      $display("FAIL mask_off: an=%b, want 1110", an);
    end
  endtask

  task automatic test_reset_mid_blank();
    load = 1'b1; din = 16'h1234;
    tick();
    load = 1'b0;
    goto_pos(16);
    n_checks++;
    if (an !== 4'b1111 || pending !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: an=%b pending=%b, want 1111 1", an, pending);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pos = 0;
    n_checks++;
    if (an !== 4'b1110 || dcba !== 4'b0000 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: an=%b dcba=%b pending=%b, want 1110 0000 0", an, dcba, pending);
    end
    for (int k = 0; k < 24; k++) begin
      n_checks++;
      if (an !== an_tab(pos, 1'b0) || dcba !== 4'b0000 || pending !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst pos%0d: an=%b dcba=%b pending=%b, want %b 0000 0",
                 pos, an, dcba, pending, an_tab(pos, 1'b0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_visible();
    test_back_to_back();
    test_commit_collision();
    test_blank_mask();
    test_reset_mid_blank();
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cd_digit_scan_mux.md
Name: cd_digit_scan_mux

Overview:
Four-digit time-multiplexed scan driver that sits directly upstream of the BCD-to-7-segment decoder. It holds a 16-bit display word of four nibbles and presents one nibble at a time on D,C,B,A. It drives active-low digit-enable (anode) lines in step with the nibble. A shadow register gives tear-free updates, and a blanking gap between digits suppresses ghosting.

Parameters:
CLK_DIV, 50000, clk cycles each digit is lit (SHOW dwell); legal range ≥2
BLANK_CYC, 8, clk cycles all anodes are off between digits (BLANK dwell); legal range ≥1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
load  input  1  single-cycle strobe; captures din into pending register
din  input  16  display word; din[3:0] = digit 0 (rightmost), din[15:12] = digit 3
blank_mask  input  4  bit i = 1 forces an[i] high (digit i dark) during its SHOW slot
D  output  1  nibble bit 3 to decoder
C  output  1  nibble bit 2
B  output  1  nibble bit 1
A  output  1  nibble bit 0
an  output  4  active-low digit enables; an[i] = 0 lights digit i
pending  output  1  high while a loaded word awaits commit

Behaviour:
- Registers:
  - disp[15:0]: shown word.
  - pend[15:0], pend_v: pending word and its valid flag.
  - idx[1:0]: current digit.
  - cnt: dwell counter, width clog2(max(CLK_DIV, BLANK_CYC)).
  - state ∈ {SHOW, BLANK}.
- Reset (rst=1 at a clk edge, overriding everything, including mid-SHOW/BLANK or a simultaneous load):
  - disp=0, pend=0, pend_v=0, idx=0, cnt=0, state=SHOW.
  - Outputs in the first post-reset cycle: an=4'b1110, {D,C,B,A}=4'b0000, pending=0.
- Output decode (from registered state only; no combinational path from inputs except blank_mask):
  - {D,C,B,A} = disp[4*idx +: 4] in both states.
  - an = 4'b1111 in BLANK.
  - an = ~(4'b0001 << idx) | blank_mask in SHOW.
- SHOW:
  - cnt increments each cycle.
  - At cnt == CLK_DIV-1: cnt←0, state←BLANK; idx unchanged.
- BLANK:
  - cnt increments each cycle.
  - At cnt == BLANK_CYC-1: cnt←0, state←SHOW, idx←idx+1 mod 4 (3→0 wraps).
- Commit:
  - On the BLANK→SHOW transition where idx goes 3→0, if pend_v=1: disp←pend and pend_v←0, in the same edge.
  - The new word is therefore first visible on digit 0 of the next frame.
  - disp never changes at any other time.
- Load:
  - load=1 sets pend←din and pend_v←1. Back-to-back loads overwrite pend; the last one wins.
  - load coincident with commit: disp←old pend, pend←din, pend_v stays 1 (new word commits next frame).
- pending = pend_v.
- Timing:
  - Frame period = 4·(CLK_DIV+BLANK_CYC) cycles.
  - Load-to-visible latency ≤ one frame + 1 cycle.
- Anode overlap: there is never a cycle with two an bits low, and idx changes only while an=4'b1111.
- blank_mask is sampled combinationally and may change anytime; it affects only an, never idx or timing.

Test Plan:
Use CLK_DIV=4, BLANK_CYC=2 (frame = 24 cycles).
1. Reset then idle → an sequence repeats 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, 1111×2; DCBA=0000 throughout; pending=0.
2. load with din=16'h4321 during digit 1 SHOW → pending=1 at once, DCBA still 0000. At the 3→0 wrap, pending=0 and DCBA steps 0001, 0010, 0011, 0100 with an 1110, 1101, 1011, 0111.
3. load 16'hAAAA then 16'h5555 two cycles later, both before the wrap → after commit every digit shows 0101; 1010 never appears.
4. load 16'h9876 exactly on the wrap-commit edge while pend=16'h1111 → next frame shows 0001 on all digits, pending stays 1; the following frame shows 6, 7, 8, 9 and pending=0.
5. blank_mask=4'b0101 → an never shows 1110 or 1011 (those slots read 1111); idx and DCBA timing are identical to scenario 1.
6. rst asserted mid-BLANK of digit 2 with pend_v=1 → next cycle an=1110, DCBA=0000, pending=0; the full reset sequence of scenario 1 resumes. Bench monitor asserts no two an bits are ever low at once.
